// File: rtl/riscv_debug_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : riscv_debug_host_seq
// Brief    : Host-side sequencer turning debug commands into SPR-bus accesses
//            with halt/step status polling and one response per command.
// Revision : 1.0
// ============================================================================
module riscv_debug_host_seq #(
    parameter int ADDR_WIDTH = 15,
    parameter int POLL_MAX   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]           cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  debug_req_o,
    input  logic                  debug_gnt_i,
    output logic [ADDR_WIDTH-1:0] debug_addr_o,
    output logic                  debug_we_o,
    output logic [31:0]           debug_wdata_o,
    input  logic                  debug_rvalid_i,
    input  logic [31:0]           debug_rdata_i
);

    localparam int c_CNT_W = $clog2(POLL_MAX + 1);

    localparam logic [2:0] c_OP_READ   = 3'd0;
    localparam logic [2:0] c_OP_WRITE  = 3'd1;
    localparam logic [2:0] c_OP_HALT   = 3'd2;
    localparam logic [2:0] c_OP_RESUME = 3'd3;
    localparam logic [2:0] c_OP_STEP   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_DBG_CTRL = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_DBG_HIT  = ADDR_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACC_REQ   = 3'd1,
        S_ACC_WAIT  = 3'd2,
        S_POLL_REQ  = 3'd3,
        S_POLL_WAIT = 3'd4,
        S_RSP       = 3'd5
    } state_t;

    state_t               r_state;
    logic [2:0]           r_op;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [ADDR_WIDTH-1:0] w_poll_addr;
    logic                  w_poll_met;
    logic                  w_needs_poll;

    // HALT watches DBG_CTRL.HALT, STEP watches DBG_HIT.SSTH
    assign w_poll_addr  = (r_op == c_OP_STEP) ? c_DBG_HIT : c_DBG_CTRL;
    assign w_poll_met   = (r_op == c_OP_STEP) ? debug_rdata_i[0] : debug_rdata_i[16];
    assign w_needs_poll = (r_op == c_OP_HALT) || (r_op == c_OP_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= 3'd0;
            r_cnt         <= '0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= 32'd0;
            rsp_err_o     <= 1'b0;
            debug_req_o   <= 1'b0;
            debug_addr_o  <= '0;
            debug_we_o    <= 1'b0;
            debug_wdata_o <= 32'd0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_o <= 1'b0;
                        r_op        <= cmd_op_i;
                        r_state     <= S_ACC_REQ;
                        debug_req_o <= 1'b1;
                        case (cmd_op_i)
                            c_OP_READ: begin
                                debug_addr_o  <= cmd_addr_i;
                                debug_we_o    <= 1'b0;
                                debug_wdata_o <= 32'd0;
                            end
                            c_OP_WRITE: begin
                                debug_addr_o  <= cmd_addr_i;
                                debug_we_o    <= 1'b1;
                                debug_wdata_o <= cmd_wdata_i;
                            end
                            c_OP_HALT: begin
                                debug_addr_o  <= c_DBG_CTRL;
                                debug_we_o    <= 1'b1;
                                debug_wdata_o <= 32'h0001_0000;
                            end
                            c_OP_RESUME: begin
                                debug_addr_o  <= c_DBG_CTRL;
                                debug_we_o    <= 1'b1;
                                debug_wdata_o <= 32'h0000_0000;
                            end
                            c_OP_STEP: begin
                                debug_addr_o  <= c_DBG_CTRL;
                                debug_we_o    <= 1'b1;
                                debug_wdata_o <= 32'h0000_0001;
                            end
                            default: begin
                                // Illegal op: skip the bus entirely
                                debug_req_o <= 1'b0;
                                r_state     <= S_RSP;
                                rsp_valid_o <= 1'b1;
                                rsp_data_o  <= 32'd0;
                                rsp_err_o   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_ACC_REQ: begin
                    if (debug_gnt_i) begin
                        debug_req_o <= 1'b0;
                        r_state     <= S_ACC_WAIT;
                    end
                end
                S_ACC_WAIT: begin
                    if (debug_rvalid_i) begin
                        if (w_needs_poll) begin
                            debug_req_o   <= 1'b1;
                            debug_addr_o  <= w_poll_addr;
                            debug_we_o    <= 1'b0;
                            debug_wdata_o <= 32'd0;
                            r_state       <= S_POLL_REQ;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= (r_op == c_OP_READ) ? debug_rdata_i : 32'd0;
                            rsp_err_o   <= 1'b0;
                            r_state     <= S_RSP;
                        end
                    end
                end
                S_POLL_REQ: begin
                    if (debug_gnt_i) begin
                        debug_req_o <= 1'b0;
                        r_cnt       <= r_cnt + c_CNT_W'(1);
                        r_state     <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (debug_rvalid_i) begin
                        if (w_poll_met || (r_cnt == c_CNT_W'(POLL_MAX))) begin
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= debug_rdata_i;
                            rsp_err_o   <= !w_poll_met;
                            r_state     <= S_RSP;
                        end else begin
                            debug_req_o <= 1'b1;
                            r_state     <= S_POLL_REQ;
                        end
                    end
                end
                S_RSP: begin
                    r_cnt       <= '0;
                    cmd_ready_o <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_cnt       <= '0;
                    debug_req_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_debug_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_debug_host_seq
// Brief    : Scoreboard bench for riscv_debug_host_seq with a scripted bus slave.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_debug_host_seq;

    localparam int AW = 15;
    localparam int PM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [2:0]    cmd_op_i = 3'd0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [31:0]   cmd_wdata_i = 32'd0;
    logic          rsp_valid_o;
    logic [31:0]   rsp_data_o;
    logic          rsp_err_o;
    logic          debug_req_o;
    logic          debug_gnt_i;
    logic [AW-1:0] debug_addr_o;
    logic          debug_we_o;
    logic [31:0]   debug_wdata_o;
    logic          debug_rvalid_i;
    logic [31:0]   debug_rdata_i;

    riscv_debug_host_seq #(.ADDR_WIDTH(AW), .POLL_MAX(PM)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .debug_req_o(debug_req_o), .debug_gnt_i(debug_gnt_i),
        .debug_addr_o(debug_addr_o), .debug_we_o(debug_we_o),
        .debug_wdata_o(debug_wdata_o), .debug_rvalid_i(debug_rvalid_i),
        .debug_rdata_i(debug_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    // scoreboard
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    int   rsp_cnt = 0;

    // bus slave configuration and access log
    int            gnt_delay = 0;
    int            rv_delay  = 1;
    int            wait_cnt  = 0;
    int            rv_cnt    = 0;
    int            cur_len   = 0;
    int            stab_err  = 0;
    int            req_seen  = 0;
    logic [31:0]   pend_data = 32'd0;
    logic [31:0]   rq[$];
    logic          acc_we[$];
    logic [AW-1:0] acc_addr[$];
    logic [31:0]   acc_wdata[$];
    int            acc_len[$];
    logic [AW-1:0] f_addr;
    logic          f_we;
    logic [31:0]   f_wd;

    initial begin
        debug_gnt_i    = 1'b0;
        debug_rvalid_i = 1'b0;
        debug_rdata_i  = 32'd0;
        forever begin
            @(negedge clk);
            debug_gnt_i    = 1'b0;
            debug_rvalid_i = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    debug_rvalid_i = 1'b1;
                    debug_rdata_i  = pend_data;
                end
            end
            if (debug_req_o) begin
                req_seen++;
                if (cur_len == 0) begin
                    f_addr = debug_addr_o; f_we = debug_we_o; f_wd = debug_wdata_o;
                end else if (debug_addr_o !== f_addr || debug_we_o !== f_we || debug_wdata_o !== f_wd) begin
                    stab_err++;
                end
                cur_len++;
                if (rv_cnt == 0 && !debug_rvalid_i && wait_cnt == gnt_delay) begin
                    debug_gnt_i = 1'b1;
                    wait_cnt    = 0;
                    rv_cnt      = rv_delay;
                    pend_data   = debug_we_o ? 32'd0 : ((rq.size() > 0) ? rq.pop_front() : 32'd0);
                    acc_we.push_back(debug_we_o);
                    acc_addr.push_back(debug_addr_o);
                    acc_wdata.push_back(debug_wdata_o);
                    acc_len.push_back(cur_len);
                    cur_len = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid_o) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got data 0x%08h err %0b, required no response",
                             rsp_data_o, rsp_err_o);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", rsp_data_o, e.data);
                    check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
                    if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input int lat);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = a; cmd_wdata_i = wd;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready 0, required 1 within 200 cycles");
            cmd_valid_i = 1'b0;
            return;
        end
        e.data = ed; e.err = ee; e.cyc = (lat >= 0) ? cyc + lat : -1;
        sb.push_back(e);
        @(negedge clk);
        // scramble inputs to prove the command was latched
        cmd_valid_i = 1'b0; cmd_op_i = 3'd7; cmd_addr_i = '1; cmd_wdata_i = 32'hFFFF_FFFF;
        check("ready_after_accept", {31'd0, cmd_ready_o}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(sb.size() == 0 && cmd_ready_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL done_timeout: got %0d responses pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int base;
        int r0;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("rst_req", {31'd0, debug_req_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_rsp_data", rsp_data_o, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        check("rst_we", {31'd0, debug_we_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // READ, minimum latency
        rq.push_back(32'hDEAD_BEEF);
        base = acc_addr.size();
        send(3'd0, 15'h0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 3);
        wait_done();
        check("read_addr", {17'd0, acc_addr[base]}, 32'h10);
        check("read_we", {31'd0, acc_we[base]}, 32'd0);
        repeat (3) @(negedge clk);
        check("read_hold", rsp_data_o, 32'hDEAD_BEEF);

        // WRITE with delayed grant
        gnt_delay = 3; stab_err = 0;
        base = acc_addr.size();
        send(3'd1, 15'h0020, 32'h1234, 32'd0, 1'b0, -1);
        wait_done();
        gnt_delay = 0;
        check("write_addr", {17'd0, acc_addr[base]}, 32'h20);
        check("write_we", {31'd0, acc_we[base]}, 32'd1);
        check("write_wdata", acc_wdata[base], 32'h1234);
        check("write_req_cycles", acc_len[base], 32'd4);
        check("write_stable", stab_err, 32'd0);

        // HALT: two polls not halted, third halted
        rq.delete();
        rq.push_back(32'h0); rq.push_back(32'h0); rq.push_back(32'h0001_0000);
        base = acc_addr.size();
        send(3'd2, 15'h7FFF, 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, -1);
        wait_done();
        check("halt_accesses", acc_addr.size() - base, 32'd4);
        check("halt_wr_addr", {17'd0, acc_addr[base]}, 32'h0);
        check("halt_wr_data", acc_wdata[base], 32'h0001_0000);
        check("halt_poll_we", {31'd0, acc_we[base+3]}, 32'd0);
        check("halt_poll_addr", {17'd0, acc_addr[base+3]}, 32'h0);

        // STEP never hits: timeout after POLL_MAX reads
        rq.delete();
        base = acc_addr.size();
        send(3'd4, 15'h0000, 32'd0, 32'd0, 1'b1, -1);
        wait_done();
        check("step_accesses", acc_addr.size() - base, 32'd5);
        check("step_wr_data", acc_wdata[base], 32'h1);
        check("step_poll_addr", {17'd0, acc_addr[base+4]}, 32'h4);

        // RESUME
        base = acc_addr.size();
        send(3'd3, 15'h0123, 32'hAAAA_5555, 32'd0, 1'b0, -1);
        wait_done();
        check("resume_accesses", acc_addr.size() - base, 32'd1);
        check("resume_we", {31'd0, acc_we[base]}, 32'd1);
        check("resume_wdata", acc_wdata[base], 32'd0);

        // Illegal op
        r0 = req_seen;
        send(3'd6, 15'h0010, 32'd0, 32'd0, 1'b1, 1);
        wait_done();
        repeat (3) @(negedge clk);
        check("illegal_no_req", req_seen - r0, 32'd0);

        // Reset while waiting for a poll read
        rv_delay = 4;
        rq.delete(); rq.push_back(32'h0);
        base = acc_addr.size();
        send(3'd2, 15'h0000, 32'd0, 32'd0, 1'b0, -1);
        n = 0;
        while (acc_addr.size() < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_poll_issued", acc_addr.size() - base, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        r0 = rsp_cnt;
        check("midrst_req", {31'd0, debug_req_o}, 32'd0);
        repeat (8) @(negedge clk);
        check("midrst_no_rsp", rsp_cnt - r0, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("midrst_rsp_data", rsp_data_o, 32'd0);
        rv_delay = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
